imem_loader: RTL and testbench

- Write-side counterpart of the instruction fetch path: receives a byte stream of program code, packs it into 32-bit little-endian words and writes them sequentially into the instruction memory write port.
- Holds the core (IFU/PC) in reset through `cpu_hold` while a load is in progress, so fetch only starts after the image is complete.
- Sits between a host byte source (UART/debug bridge) and the instruction memory.

---
 rtl/imem_loader_pkg.sv | 31 +++
 rtl/imem_loader_packer.sv | 39 +++
 rtl/imem_loader.sv | 141 ++++++++++++++
 tb/tb_imem_loader.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader.
// - state_t     : loader FSM state encodings
// - WORD_BYTES  : bytes per instruction word
// - insert_lane : little-endian byte-lane insert (lane 0 -> bits [7:0]);
//                 the same lane convention is used by the instruction memory.
package imem_loader_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int unsigned WORD_BYTES = 4;
    localparam int unsigned LANE_W     = 8;

    function automatic logic [31:0] insert_lane(input logic [31:0] word,
                                                input logic [1:0]  lane,
                                                input logic [7:0]  data);
        logic [31:0] r;
        r = word;
        for (int unsigned i = 0; i < WORD_BYTES; i++) begin
            if (lane == 2'(i)) begin
                r[i*LANE_W +: LANE_W] = data;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/imem_loader_packer.sv
// byte_packer: assembles accepted bytes into a 32-bit little-endian word.
// Ports:
//   clock, reset : clock and async active-high reset
//   clear        : drop any partial word and restart at lane 0
//   accept       : byte_data is taken into the current lane this cycle
//   byte_data    : incoming byte
//   word         : assembled word (complete in the cycle after word_full)
//   word_full    : this accept fills the last lane
module byte_packer (
    input  logic        clock,
    input  logic        reset,
    input  logic        clear,
    input  logic        accept,
    input  logic [7:0]  byte_data,
    output logic [31:0] word,
    output logic        word_full
);
    import imem_loader_pkg::*;

    logic [1:0]  byte_idx;
    logic [31:0] word_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            byte_idx <= '0;
            word_q   <= '0;
        end else if (clear) begin
            byte_idx <= '0;
            word_q   <= '0;
        end else if (accept) begin
            word_q   <= insert_lane(word_q, byte_idx, byte_data);
            byte_idx <= byte_idx + 2'd1;
        end
    end

    assign word      = word_q;
    assign word_full = accept && (byte_idx == 2'(WORD_BYTES - 1));

endmodule

// File: rtl/imem_loader.sv
// imem_loader: packs a host byte stream into 32-bit words and writes them
// sequentially into instruction memory, holding the core while loading.
// Ports:
//   clock, reset            : clock and async active-high reset
//   load_start, load_len    : begin a load of load_len words (IDLE only)
//   load_abort              : terminate an in-progress load
//   byte_valid, byte_data   : host byte stream; byte_ready is the accept
//   mem_we, mem_addr, mem_wdata : instruction memory write port
//   cpu_hold                : core hold while a load is in progress
//   load_done               : one-cycle pulse on successful completion
//   load_error              : sticky error (bad length or abort)
module imem_loader #(
    parameter int unsigned MEM_WORDS = 64,
    parameter int unsigned LEN_W     = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load_start,
    input  logic [LEN_W-1:0] load_len,
    input  logic             load_abort,
    input  logic             byte_valid,
    input  logic [7:0]       byte_data,
    output logic             byte_ready,
    output logic             mem_we,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    output logic             cpu_hold,
    output logic             load_done,
    output logic             load_error
);
    import imem_loader_pkg::*;

    localparam int unsigned CNT_W = $clog2(MEM_WORDS + 1);

    state_t           state, state_next;
    logic [CNT_W-1:0] len_q;
    logic [CNT_W-1:0] word_cnt;
    logic [CNT_W-1:0] word_cnt_inc;
    logic [31:0]      cur_addr;
    logic [31:0]      addr_hold;
    logic [31:0]      wdata_hold;
    logic [31:0]      packed_word;
    logic             word_full;
    logic             start_ok;
    logic             accept;
    logic             packer_clear;
    logic             last_word;

    assign start_ok     = load_start && (load_len != '0) &&
                          (load_len <= LEN_W'(MEM_WORDS));
    // Abort wins over a coincident byte: the byte is never taken.
    assign accept       = byte_valid && byte_ready && !load_abort;
    assign packer_clear = ((state == IDLE) && start_ok) ||
                          ((state == LOAD) && load_abort);
    assign word_cnt_inc = word_cnt + CNT_W'(1);
    assign last_word    = (word_cnt_inc == len_q);
    assign cur_addr     = {{(32 - CNT_W - 2){1'b0}}, word_cnt, 2'b00};

    byte_packer u_packer (
        .clock     (clock),
        .reset     (reset),
        .clear     (packer_clear),
        .accept    (accept),
        .byte_data (byte_data),
        .word      (packed_word),
        .word_full (word_full)
    );

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start_ok) state_next = LOAD;
            LOAD: begin
                if (load_abort)     state_next = IDLE;
                else if (word_full) state_next = WRITE;
            end
            WRITE: begin
                if (load_abort)     state_next = IDLE;
                else if (last_word) state_next = DONE;
                else                state_next = LOAD;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output logic; the write port shows the live word only during WRITE
    // and otherwise replays the last written address/data.
    always_comb begin
        byte_ready = (state == LOAD);
        mem_we     = (state == WRITE);
        cpu_hold   = (state != IDLE);
        load_done  = (state == DONE);
        mem_addr   = mem_we ? cur_addr    : addr_hold;
        mem_wdata  = mem_we ? packed_word : wdata_hold;
    end

    // Datapath: length latch, word counter, write hold and error flag
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            len_q      <= '0;
            word_cnt   <= '0;
            addr_hold  <= '0;
            wdata_hold <= '0;
            load_error <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_ok) begin
                        len_q      <= load_len[CNT_W-1:0];
                        word_cnt   <= '0;
                        load_error <= 1'b0;
                    end else if (load_start) begin
                        load_error <= 1'b1;
                    end
                end
                LOAD: begin
                    if (load_abort) load_error <= 1'b1;
                end
                WRITE: begin
                    word_cnt   <= word_cnt_inc;
                    addr_hold  <= cur_addr;
                    wdata_hold <= packed_word;
                    if (load_abort) load_error <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;

    logic        clock = 1'b0;
    logic        reset;
    logic        load_start;
    logic [15:0] load_len;
    logic        load_abort;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        cpu_hold;
    logic        load_done;
    logic        load_error;

    int checks = 0;
    int failures = 0;

    imem_loader #(.MEM_WORDS(64), .LEN_W(16)) dut (
        .clock      (clock),
        .reset      (reset),
        .load_start (load_start),
        .load_len   (load_len),
        .load_abort (load_abort),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .cpu_hold   (cpu_hold),
        .load_done  (load_done),
        .load_error (load_error)
    );

    always #5 clock = ~clock;

    // Event log sampled on the falling edge
    int          cyc = 0;
    logic [31:0] wr_addr[$];
    logic [31:0] wr_data[$];
    int          wr_cyc[$];
    int          acc_cyc[$];
    int          done_cnt;
    int          done_cyc;
    logic        hold_at_done;
    logic        hold_after_done;
    bit          done_pending;
    int          ready_viol = 0;

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if (mem_we) begin
            wr_addr.push_back(mem_addr);
            wr_data.push_back(mem_wdata);
            wr_cyc.push_back(cyc);
        end
        if (byte_valid && byte_ready && !load_abort) acc_cyc.push_back(cyc);
        if (byte_ready !== (cpu_hold && !mem_we && !load_done)) ready_viol++;
        if (done_pending) begin
            hold_after_done = cpu_hold;
            done_pending    = 1'b0;
        end
        if (load_done) begin
            done_cnt++;
            done_cyc     = cyc;
            hold_at_done = cpu_hold;
            done_pending = 1'b1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_log();
        wr_addr.delete();
        wr_data.delete();
        wr_cyc.delete();
        acc_cyc.delete();
        done_cnt        = 0;
        done_cyc        = 0;
        hold_at_done    = 1'b0;
        hold_after_done = 1'b1;
        done_pending    = 1'b0;
    endtask

    task automatic start_load(input logic [15:0] len);
        load_start = 1'b1;
        load_len   = len;
        tick();
        load_start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        bit ok;
        ok         = 1'b0;
        byte_valid = 1'b1;
        byte_data  = b;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (byte_ready) begin
                ok = 1'b1;
                break;
            end
        end
        tick();
        byte_valid = 1'b0;
        check("byte_ready_wait", {31'b0, ok}, 32'd1);
        repeat (gap) tick();
    endtask

    task automatic wait_done(input int budget);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (done_cnt > 0) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        check("done_wait", {31'b0, seen}, 32'd1);
        tick();
        tick();
    endtask

    logic [7:0] img[8] = '{8'h13, 8'h05, 8'h50, 8'h00, 8'hB3, 8'h05, 8'hB5, 8'h00};

    task automatic check_img(input string tag);
        check({tag, "_nwr"},  wr_addr.size(), 32'd2);
        check({tag, "_a0"},   wr_addr[0], 32'h0);
        check({tag, "_d0"},   wr_data[0], 32'h00500513);
        check({tag, "_a1"},   wr_addr[1], 32'h4);
        check({tag, "_d1"},   wr_data[1], 32'h00B505B3);
        check({tag, "_lat0"}, wr_cyc[0], acc_cyc[3] + 1);
        check({tag, "_lat1"}, wr_cyc[1], acc_cyc[7] + 1);
        check({tag, "_ndone"}, done_cnt, 32'd1);
        check({tag, "_done_lat"}, done_cyc, wr_cyc[1] + 1);
        check({tag, "_hold_done"}, {31'b0, hold_at_done}, 32'd1);
        check({tag, "_hold_after"}, {31'b0, hold_after_done}, 32'd0);
    endtask

    initial begin
        reset      = 1'b1;
        load_start = 1'b0;
        load_len   = '0;
        load_abort = 1'b0;
        byte_valid = 1'b0;
        byte_data  = '0;
        clear_log();
        tick();
        tick();
        check("rst_ctrl", {27'b0, byte_ready, mem_we, cpu_hold, load_done, load_error}, 32'd0);
        check("rst_addr", mem_addr, 32'd0);
        check("rst_wdata", mem_wdata, 32'd0);
        reset = 1'b0;
        tick();

        // Directed len=2 load, back-to-back bytes
        clear_log();
        start_load(16'd2);
        check("t1_hold_start", {31'b0, cpu_hold}, 32'd1);
        for (int i = 0; i < 8; i++) send_byte(img[i], 0);
        wait_done(20);
        check_img("t1");
        check("t1_hold_idle", {31'b0, cpu_hold}, 32'd0);

        // Same image with random idle gaps
        clear_log();
        start_load(16'd2);
        for (int i = 0; i < 8; i++) send_byte(img[i], int'($urandom_range(0, 3)));
        wait_done(20);
        check_img("t2");
        check("t2_ready_rule", ready_viol, 32'd0);

        // Illegal lengths
        clear_log();
        start_load(16'd0);
        check("t3_err_len0", {31'b0, load_error}, 32'd1);
        check("t3_hold_len0", {31'b0, cpu_hold}, 32'd0);
        start_load(16'd65);
        check("t3_err_len65", {31'b0, load_error}, 32'd1);
        repeat (3) tick();
        check("t3_hold_len65", {31'b0, cpu_hold}, 32'd0);
        check("t3_nwr", wr_addr.size(), 32'd0);
        start_load(16'd1);
        check("t3_err_clear", {31'b0, load_error}, 32'd0);
        send_byte(8'h44, 0);
        send_byte(8'h33, 0);
        send_byte(8'h22, 0);
        send_byte(8'h11, 0);
        wait_done(20);
        check("t3_a0", wr_addr[0], 32'h0);
        check("t3_d0", wr_data[0], 32'h11223344);

        // Abort after 6 bytes, with a coincident byte that must be dropped
        clear_log();
        start_load(16'd2);
        for (int i = 0; i < 6; i++) send_byte(img[i], 0);
        load_abort = 1'b1;
        byte_valid = 1'b1;
        byte_data  = 8'hFF;
        tick();
        load_abort = 1'b0;
        byte_valid = 1'b0;
        check("t4_err", {31'b0, load_error}, 32'd1);
        check("t4_hold", {31'b0, cpu_hold}, 32'd0);
        check("t4_ready", {31'b0, byte_ready}, 32'd0);
        repeat (5) tick();
        check("t4_nwr", wr_addr.size(), 32'd1);
        check("t4_a0", wr_addr[0], 32'h0);
        check("t4_d0", wr_data[0], 32'h00500513);
        check("t4_ndone", done_cnt, 32'd0);

        // Asynchronous reset mid-word
        start_load(16'd1);
        send_byte(8'hAA, 0);
        send_byte(8'hBB, 0);
        #2;
        reset = 1'b1;
        #1;
        check("t5_ctrl", {27'b0, byte_ready, mem_we, cpu_hold, load_done, load_error}, 32'd0);
        check("t5_addr", mem_addr, 32'd0);
        check("t5_wdata", mem_wdata, 32'd0);
        @(negedge clock);
        reset = 1'b0;
        tick();
        clear_log();
        start_load(16'd1);
        send_byte(8'h01, 0);
        send_byte(8'h02, 0);
        send_byte(8'h03, 0);
        send_byte(8'h04, 0);
        wait_done(20);
        check("t5_nwr", wr_addr.size(), 32'd1);
        check("t5_a0", wr_addr[0], 32'h0);
        check("t5_d0", wr_data[0], 32'h04030201);

        // Full-depth load with a stray load_start mid-load
        clear_log();
        start_load(16'd64);
        for (int i = 0; i < 256; i++) begin
            if (i == 100) begin
                load_start = 1'b1;
                load_len   = 16'd5;
            end
            send_byte(8'(i), 0);
            load_start = 1'b0;
        end
        wait_done(20);
        check("t6_nwr", wr_addr.size(), 32'd64);
        for (int w = 0; w < 64; w++) begin
            check($sformatf("t6_a%0d", w), wr_addr[w], 32'(w * 4));
            check($sformatf("t6_d%0d", w), wr_data[w],
                  {8'(4*w + 3), 8'(4*w + 2), 8'(4*w + 1), 8'(4*w)});
        end
        check("t6_last_addr", wr_addr[63], 32'hFC);
        check("t6_ndone", done_cnt, 32'd1);
        check("t6_hold_idle", {31'b0, cpu_hold}, 32'd0);
        check("ready_rule", ready_viol, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
